// File: rtl/mssd_serial_demux.sv
// Serial frame decoder: start bit, 2-bit port, 4-bit length, len+1 payload bits, stop bit.
// Payload bits are steered onto one of four registered port outputs with a valid strobe.
module mssd_serial_demux (
  input  logic       clk,
  input  logic       rst,
  input  logic       SerIn,
  output logic       outValid,
  output logic [1:0] pn,
  output logic       error,
  output logic       p3,
  output logic       p2,
  output logic       p1,
  output logic       p0
);

  typedef enum logic [2:0] {
    IDLE,
    PORT,
    LEN,
    DATA,
    STOP
  } state_t;

  state_t      state, state_n;
  logic [1:0]  sub_cnt, sub_cnt_n;
  logic        pn_hi, pn_hi_n;
  logic [1:0]  pn_n;
  logic [2:0]  len_sh, len_sh_n;
  logic [3:0]  data_cnt, data_cnt_n;
  logic [3:0]  p_q, p_n;
  logic        out_valid_n, error_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sub_cnt  <= '0;
      pn_hi    <= 1'b0;
      pn       <= '0;
      len_sh   <= '0;
      data_cnt <= '0;
      p_q      <= '0;
      outValid <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_n;
      sub_cnt  <= sub_cnt_n;
      pn_hi    <= pn_hi_n;
      pn       <= pn_n;
      len_sh   <= len_sh_n;
      data_cnt <= data_cnt_n;
      p_q      <= p_n;
      outValid <= out_valid_n;
      error    <= error_n;
    end
  end

  always_comb begin
    state_n     = state;
    sub_cnt_n   = sub_cnt;
    pn_hi_n     = pn_hi;
    pn_n        = pn;
    len_sh_n    = len_sh;
    data_cnt_n  = data_cnt;
    p_n         = '0;
    out_valid_n = 1'b0;
    error_n     = 1'b0;
    case (state)
      IDLE: begin
        if (!SerIn) begin
          state_n   = PORT;
          sub_cnt_n = '0;
        end
      end
      PORT: begin
        // pn is only published once both port bits are in, so it holds during the next port field
        if (sub_cnt == 2'd0) begin
          pn_hi_n   = SerIn;
          sub_cnt_n = 2'd1;
        end else begin
          pn_n      = {pn_hi, SerIn};
          sub_cnt_n = '0;
          state_n   = LEN;
        end
      end
      LEN: begin
        if (sub_cnt == 2'd3) begin
          data_cnt_n = {len_sh, SerIn};
          sub_cnt_n  = '0;
          state_n    = DATA;
        end else begin
          len_sh_n  = {len_sh[1:0], SerIn};
          sub_cnt_n = sub_cnt + 2'd1;
        end
      end
      DATA: begin
        // down-counter reaches zero on the last payload bit, so len=15 gives 16 bits without wrap
        out_valid_n = 1'b1;
        p_n[pn]     = SerIn;
        if (data_cnt == 4'd0) begin
          state_n = STOP;
        end else begin
          data_cnt_n = data_cnt - 4'd1;
        end
      end
      STOP: begin
        error_n = ~SerIn;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign {p3, p2, p1, p0} = p_q;

endmodule

// File: tb/tb_mssd_serial_demux.sv
// Scoreboard bench for mssd_serial_demux: frame-level reference model feeds expected
// payload/error events; a negedge monitor pops and compares them, with cycle stamps.
module tb_mssd_serial_demux;

  logic       clk = 1'b0;
  logic       rst;
  logic       SerIn;
  logic       outValid;
  logic [1:0] pn;
  logic       error;
  logic       p3, p2, p1, p0;

  mssd_serial_demux dut (
    .clk     (clk),
    .rst     (rst),
    .SerIn   (SerIn),
    .outValid(outValid),
    .pn      (pn),
    .error   (error),
    .p3      (p3),
    .p2      (p2),
    .p1      (p1),
    .p0      (p0)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  pn;
    logic [3:0]  p;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned err_q[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        active = 1'b0;
  logic        rst_seen = 1'b0;
  exp_t        e;
  int unsigned ecyc;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // Monitor: outputs settled after the edge; cyc already counts that edge.
  always @(negedge clk) begin
    if (active) begin
      if (rst_seen) begin
        checks++;
        if (outValid !== 1'b0 || error !== 1'b0 || pn !== 2'b00 || {p3, p2, p1, p0} !== 4'b0000) begin
          errors++;
          $display("FAIL reset_state: cyc=%0d outValid=%b error=%b pn=%b p=%b, required all zero",
                   cyc, outValid, error, pn, {p3, p2, p1, p0});
        end
      end else begin
        checks++;
        if (outValid === 1'b1) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: cyc=%0d pn=%b p=%b, required no valid", cyc, pn, {p3, p2, p1, p0});
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || pn !== e.pn || {p3, p2, p1, p0} !== e.p) begin
              errors++;
              $display("FAIL payload: got cyc=%0d pn=%b p=%b, required cyc=%0d pn=%b p=%b",
                       cyc, pn, {p3, p2, p1, p0}, e.cyc, e.pn, e.p);
            end
          end
        end else if (outValid !== 1'b0 || {p3, p2, p1, p0} !== 4'b0000) begin
          errors++;
          $display("FAIL idle_outputs: cyc=%0d outValid=%b p=%b, required 0 and 0000",
                   cyc, outValid, {p3, p2, p1, p0});
        end
        if (error === 1'b1) begin
          checks++;
          if (err_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_error: cyc=%0d error=1, required 0", cyc);
          end else begin
            ecyc = err_q.pop_front();
            if (ecyc != cyc) begin
              errors++;
              $display("FAIL error_timing: error at cyc=%0d, required cyc=%0d", cyc, ecyc);
            end
          end
        end else if (error !== 1'b0) begin
          checks++;
          errors++;
          $display("FAIL error_level: cyc=%0d error=%b, required 0", cyc, error);
        end
      end
    end
  end

  task automatic drive(input logic b);
    SerIn = b;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a payload bit driven now is sampled at the next edge and seen then.
  task automatic send_frame(input logic [1:0] fpn, input logic [3:0] flen,
                            input logic [15:0] pay, input logic stop, input int rst_at);
    exp_t x;
    drive(1'b0);
    drive(fpn[1]);
    drive(fpn[0]);
    for (int i = 3; i >= 0; i--) drive(flen[i]);
    for (int i = 0; i <= int'(flen); i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        drive(pay[i]);
        rst = 1'b0;
        return;
      end
      x.cyc = cyc + 1;
      x.pn  = fpn;
      x.p   = pay[i] ? (4'b0001 << fpn) : 4'b0000;
      exp_q.push_back(x);
      drive(pay[i]);
    end
    if (!stop) err_q.push_back(cyc + 1);
    drive(stop);
  endtask

  initial begin
    logic [1:0]  rpn;
    logic [3:0]  rlen;
    logic [15:0] rpay;
    logic        rstop;
    rst   = 1'b1;
    SerIn = 1'($urandom);
    @(posedge clk);
    #1;
    active = 1'b1;
    drive(1'($urandom));
    drive(1'($urandom));
    rst = 1'b0;
    drive(1'b1);
    drive(1'b1);

    // basic frame: pn=10, len=2, payload 1,1,0
    send_frame(2'b10, 4'b0010, 16'h0003, 1'b1, -1);
    drive(1'b1);
    // port sweep, back-to-back
    for (int k = 0; k < 4; k++) send_frame(2'(k), 4'b0000, 16'h0001, 1'b1, -1);
    drive(1'b1);
    // max length, alternating 1,0
    send_frame(2'b01, 4'b1111, 16'h5555, 1'b1, -1);
    // bad stop followed by a good frame
    send_frame(2'b11, 4'b0001, 16'h0003, 1'b0, -1);
    drive(1'b1);
    send_frame(2'b00, 4'b0010, 16'h0005, 1'b1, -1);
    // reset during the 2nd payload bit
    send_frame(2'b10, 4'b0100, 16'h001F, 1'b1, 1);
    drive(1'b1);
    send_frame(2'b01, 4'b0011, 16'h0009, 1'b1, -1);

    for (int k = 0; k < 40; k++) begin
      rpn   = 2'($urandom);
      rlen  = 4'($urandom);
      rpay  = 16'($urandom);
      rstop = ($urandom_range(0, 4) != 0);
      send_frame(rpn, rlen, rpay, rstop, -1);
      for (int g = $urandom_range(0, 3); g > 0; g--) drive(1'b1);
    end

    drive(1'b1);
    drive(1'b1);
    drive(1'b1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_payload: %0d expected payload cycles never seen, required 0", exp_q.size());
    end
    checks++;
    if (err_q.size() != 0) begin
      errors++;
      $display("FAIL missing_error: %0d expected error pulses never seen, required 0", err_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mssd_serial_demux.md
Name: mssd_serial_demux

Overview:
- Serial frame decoder/demultiplexer. Receives framed packets on a single serial line `SerIn`.
- Decodes a 2-bit port number and a 4-bit length field, then steers each payload bit onto one of four parallel port outputs `p0`..`p3`, with an `outValid` strobe.
- Flags a malformed frame (bad stop bit) on `error`.
- Sits between a serial link receiver and four downstream single-bit consumers.

Parameters:
- None. Field widths are fixed: port number 2 bits, length 4 bits, 4 output ports.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `SerIn`  in  1  serial input; line idles high; sampled on each rising edge
- `outValid`  out  1  high while a payload bit is presented on the selected port
- `pn`  out  2  port number of the current/last frame
- `error`  out  1  one-cycle pulse on an invalid stop bit
- `p3`  out  1  port 3 data
- `p2`  out  1  port 2 data
- `p1`  out  1  port 1 data
- `p0`  out  1  port 0 data

Behaviour:
- One clock domain, `clk`. Reset is synchronous and active-high.
- All outputs are registered and update only on the rising edge of `clk`.
- Reset (`rst`=1 at a rising edge):
  - Go to IDLE.
  - `outValid`=0, `error`=0, `pn`=00, `p3..p0`=0000, internal counters cleared.
  - Reset has priority over every other event, including mid-frame: the frame is discarded with no error.
- Frame format, MSB first, one bit per clock:
  - start bit 0
  - `pn[1]`, `pn[0]`
  - `len[3:0]`
  - `len`+1 payload bits (1..16)
  - stop bit 1
- FSM states: IDLE, PORT (2 cycles), LEN (4 cycles), DATA (`len`+1 cycles), STOP (1 cycle).
- IDLE:
  - `SerIn`=1 → stay in IDLE.
  - `SerIn`=0 → PORT.
- PORT:
  - Shift 2 bits into the port register, then go to LEN.
  - The `pn` output updates when the second port bit is sampled and holds until the next frame's port field completes.
- LEN: shift 4 bits into the length register, then go to DATA; load the down-counter with `len`.
- DATA:
  - On the edge that samples a payload bit: `outValid`←1, `p[pn]`←sampled bit, the other three `p` bits←0.
  - After `len`+1 bits, go to STOP.
  - Latency: the bit sampled at edge k is visible on the outputs from edge k until edge k+1.
- STOP:
  - On the sampling edge: `outValid`←0, `p`←0000.
  - `SerIn`=0 → `error`←1 for exactly one cycle.
  - Always return to IDLE.
- Outside DATA: `outValid`=0, `p3..p0`=0000, `error`=0 except the stop pulse.
- Back-to-back frames:
  - A 0 sampled in the cycle right after STOP starts a new frame.
  - After a bad stop bit, the next 0 sampled in IDLE starts a new frame.
- At most one `p` bit is nonzero at any time, and only while `outValid`=1.
- Consumers may ignore `pn` and `p` while `outValid`=0. They are still required to follow the rules above (`p`=0000).
- Counters must not wrap. `len`=1111 yields exactly 16 payload cycles.

Test Plan:
- Reset: hold `rst`=1 with `SerIn` random for 3 cycles → `outValid`=0, `error`=0, `pn`=00, `p`=0000 every cycle.
- Basic frame: `SerIn` = 0, 1,0, 0,0,1,0, 1,1,0, 1 → 3 cycles of `outValid`=1 with `pn`=10, `p3..p0` = 0100, 0100, 0000; then `outValid`=0, `error`=0.
- Port sweep: four frames with `pn`=00,01,10,11, `len`=0000, payload 1, stop 1 → one `outValid` cycle each with `p`=0001, 0010, 0100, 1000 respectively.
- Max length: `pn`=01, `len`=1111, payload alternating 1,0 → exactly 16 `outValid` cycles with `p` alternating 0010/0000; no wrap.
- Bad stop: `pn`=11, `len`=0001, payload 1,1, stop 0 → 2 `outValid` cycles with `p`=1000, then a single-cycle `error`=1; a following frame decodes normally.
- Reset mid-frame: assert `rst` during the 2nd payload bit of a `len`=0100 frame → next cycle all outputs 0, IDLE, no error; a subsequent frame decodes correctly.
